// File: rtl/ast_width_reducer_pkg.sv
// Shared types and helpers for the Avalon-ST width reducer and its bench.
package ast_wr_package;

    typedef enum logic {
        ST_EMPTY   = 1'b0,
        ST_SENDING = 1'b1
    } wr_state_e;

    typedef enum logic [2:0] {
        TEST_PLAIN        = 3'd0,
        TEST_EMPTY        = 3'd1,
        TEST_BACKPRESSURE = 3'd2,
        TEST_CHANNELS     = 3'd3,
        TEST_RANDOM_BIG   = 3'd4
    } test_case_e;

    localparam int unsigned PKT_LEN_MIN = 1;
    localparam int unsigned PKT_LEN_MAX = 256;

    // Number of narrow words needed to carry a byte count; never less than one.
    function automatic int unsigned words_for_bytes(input int unsigned bytes,
                                                    input int unsigned word_b);
        int unsigned n;
        n = (bytes + word_b - 1) / word_b;
        return (n == 0) ? 1 : n;
    endfunction

endpackage

// File: rtl/ast_width_reducer.sv
// Avalon-ST width reducer: holds one wide beat and replays it as narrow words,
// lowest slice first, preserving sop/eop/empty/channel.
module ast_width_reducer
    import ast_wr_package::*;
#(
    parameter int unsigned DATA_IN_W   = 256,
    parameter int unsigned EMPTY_IN_W  = ((DATA_IN_W / 8) > 1) ? $clog2(DATA_IN_W / 8) : 1,
    parameter int unsigned CHANNEL_W   = 10,
    parameter int unsigned DATA_OUT_W  = 64,
    parameter int unsigned EMPTY_OUT_W = ((DATA_OUT_W / 8) > 1) ? $clog2(DATA_OUT_W / 8) : 1
) (
    input  logic                   clk_i,
    input  logic                   srst_i,

    input  logic [DATA_IN_W-1:0]   ast_data_i,
    input  logic                   ast_startofpacket_i,
    input  logic                   ast_endofpacket_i,
    input  logic                   ast_valid_i,
    input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
    input  logic [CHANNEL_W-1:0]   ast_channel_i,
    output logic                   ast_ready_o,

    output logic [DATA_OUT_W-1:0]  ast_data_o,
    output logic                   ast_startofpacket_o,
    output logic                   ast_endofpacket_o,
    output logic                   ast_valid_o,
    output logic [EMPTY_OUT_W-1:0] ast_empty_o,
    output logic [CHANNEL_W-1:0]   ast_channel_o,
    input  logic                   ast_ready_i
);

    localparam int unsigned RATIO = DATA_IN_W / DATA_OUT_W;
    localparam int unsigned IN_B  = DATA_IN_W / 8;
    localparam int unsigned OUT_B = DATA_OUT_W / 8;
    localparam int unsigned IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    wr_state_e              r_state;
    wr_state_e              w_state_nxt;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       w_idx_nxt;

    logic [DATA_IN_W-1:0]   r_data;
    logic                   r_sop;
    logic                   r_eop;
    logic [CHANNEL_W-1:0]   r_channel;
    logic [IDX_W-1:0]       r_last_idx;
    logic [EMPTY_OUT_W-1:0] r_empty_out;

    logic [IDX_W-1:0]       w_last_idx_in;
    logic [EMPTY_OUT_W-1:0] w_empty_out_in;
    int unsigned            w_bytes;
    int unsigned            w_words;

    logic                   w_last_word;
    logic                   w_word_hs;
    logic                   w_accept;

    assign w_last_word = (r_state == ST_SENDING) && (r_idx == r_last_idx);
    assign w_word_hs   = (r_state == ST_SENDING) && ast_ready_i;
    assign w_accept    = ast_valid_i && ast_ready_o;

    // Word count and trailing empty of the incoming beat, resolved before it is held.
    always_comb begin
        w_bytes        = IN_B;
        w_words        = RATIO;
        w_last_idx_in  = IDX_W'(RATIO - 1);
        w_empty_out_in = '0;
        if (ast_endofpacket_i) begin
            w_bytes        = (32'(ast_empty_i) < IN_B) ? (IN_B - 32'(ast_empty_i)) : 1;
            w_words        = words_for_bytes(w_bytes, OUT_B);
            w_last_idx_in  = IDX_W'(w_words - 1);
            w_empty_out_in = EMPTY_OUT_W'(w_words * OUT_B - w_bytes);
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state <= ST_EMPTY;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_SENDING;
                    w_idx_nxt   = '0;
                end
            end
            ST_SENDING: begin
                if (w_word_hs) begin
                    if (w_last_word) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = w_accept ? ST_SENDING : ST_EMPTY;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Holding register: one wide beat plus its precomputed framing.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_data      <= '0;
            r_sop       <= 1'b0;
            r_eop       <= 1'b0;
            r_channel   <= '0;
            r_last_idx  <= '0;
            r_empty_out <= '0;
        end else if (w_accept) begin
            r_data      <= ast_data_i;
            r_sop       <= ast_startofpacket_i;
            r_eop       <= ast_endofpacket_i;
            r_channel   <= ast_channel_i;
            r_last_idx  <= w_last_idx_in;
            r_empty_out <= w_empty_out_in;
        end
    end

    // Ready may pass straight through from downstream on the last word for gapless streaming.
    always_comb begin
        ast_ready_o         = !srst_i && ((r_state == ST_EMPTY) || (ast_ready_i && w_last_word));
        ast_valid_o         = (r_state == ST_SENDING);
        ast_data_o          = r_data[32'(r_idx) * DATA_OUT_W +: DATA_OUT_W];
        ast_startofpacket_o = (r_state == ST_SENDING) && r_sop && (r_idx == '0);
        ast_endofpacket_o   = w_last_word && r_eop;
        ast_empty_o         = (w_last_word && r_eop) ? r_empty_out : '0;
        ast_channel_o       = r_channel;
    end

endmodule

// File: tb/tb_ast_width_reducer.sv
// Scoreboard bench for ast_width_reducer: expected narrow words are queued as packets
// are generated and checked as the reducer emits them.
module tb_ast_width_reducer;
    import ast_wr_package::*;

    localparam int unsigned DIN   = 256;
    localparam int unsigned DOUT  = 64;
    localparam int unsigned IN_B  = DIN / 8;
    localparam int unsigned OUT_B = DOUT / 8;
    localparam int unsigned CW    = 10;
    localparam int unsigned EIW   = 5;
    localparam int unsigned EOW   = 3;
    localparam int unsigned HALF  = 5;

    typedef struct packed {
        logic [DOUT-1:0] data;
        logic            sop;
        logic            eop;
        logic [EOW-1:0]  empty;
        logic [CW-1:0]   ch;
    } word_t;

    logic            clk = 1'b0;
    logic            srst_i = 1'b1;
    logic [DIN-1:0]  ast_data_i = '0;
    logic            ast_startofpacket_i = 1'b0;
    logic            ast_endofpacket_i = 1'b0;
    logic            ast_valid_i = 1'b0;
    logic [EIW-1:0]  ast_empty_i = '0;
    logic [CW-1:0]   ast_channel_i = '0;
    logic            ast_ready_o;
    logic [DOUT-1:0] ast_data_o;
    logic            ast_startofpacket_o;
    logic            ast_endofpacket_o;
    logic            ast_valid_o;
    logic [EOW-1:0]  ast_empty_o;
    logic [CW-1:0]   ast_channel_o;
    logic            ast_ready_i = 1'b1;

    always #HALF clk = ~clk;

    ast_width_reducer dut (
        .clk_i               (clk),
        .srst_i              (srst_i),
        .ast_data_i          (ast_data_i),
        .ast_startofpacket_i (ast_startofpacket_i),
        .ast_endofpacket_i   (ast_endofpacket_i),
        .ast_valid_i         (ast_valid_i),
        .ast_empty_i         (ast_empty_i),
        .ast_channel_i       (ast_channel_i),
        .ast_ready_o         (ast_ready_o),
        .ast_data_o          (ast_data_o),
        .ast_startofpacket_o (ast_startofpacket_o),
        .ast_endofpacket_o   (ast_endofpacket_o),
        .ast_valid_o         (ast_valid_o),
        .ast_empty_o         (ast_empty_o),
        .ast_channel_o       (ast_channel_o),
        .ast_ready_i         (ast_ready_i)
    );

    word_t      exp_q[$];
    time        acc_t[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         bp_mode = 0;
    int         words_seen = 0;
    time        t_first = 0;
    time        t_last = 0;
    test_case_e cur_test = TEST_PLAIN;

    // Downstream: drives ready per mode and checks every accepted word against the queue.
    initial begin
        word_t got;
        word_t exp;
        forever begin
            @(negedge clk);
            case (bp_mode)
                0:       ast_ready_i = 1'b1;
                1:       ast_ready_i = 1'($urandom_range(1, 0));
                default: ast_ready_i = 1'b0;
            endcase
            #1;
            if (ast_valid_o === 1'b1 && ast_ready_i) begin
                got = '{ast_data_o, ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_channel_o};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL %s extra_word: got data=%h sop=%b eop=%b empty=%0d ch=%0d, none expected",
                             cur_test.name(), got.data, got.sop, got.eop, got.empty, got.ch);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        n_err++;
                        $display("FAIL %s word%0d: got data=%h sop=%b eop=%b empty=%0d ch=%0d, want data=%h sop=%b eop=%b empty=%0d ch=%0d",
                                 cur_test.name(), words_seen, got.data, got.sop, got.eop, got.empty, got.ch,
                                 exp.data, exp.sop, exp.eop, exp.empty, exp.ch);
                    end
                end
                if (words_seen == 0) t_first = $time;
                t_last = $time;
                words_seen++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_beat(input logic [DIN-1:0] d, input logic sop, input logic eop,
                              input logic [EIW-1:0] emp, input logic [CW-1:0] ch);
        int guard;
        guard = 0;
        @(negedge clk);
        ast_data_i          = d;
        ast_startofpacket_i = sop;
        ast_endofpacket_i   = eop;
        ast_empty_i         = emp;
        ast_channel_i       = ch;
        ast_valid_i         = 1'b1;
        #2;
        while (ast_ready_o !== 1'b1) begin
            guard++;
            if (guard > 2000) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s accept_timeout: ready_o=%b after %0d cycles, want 1", cur_test.name(), ast_ready_o, guard);
                break;
            end
            @(negedge clk);
            #2;
        end
        @(posedge clk);
        acc_t.push_back($time);
        #1;
        ast_valid_i = 1'b0;
    endtask

    task automatic send_packet(input int len, input logic [CW-1:0] ch, input bit rnd);
        logic [7:0] pkt[$];
        int nw;
        int nb;
        for (int i = 0; i < len; i++) pkt.push_back(rnd ? 8'($urandom) : 8'(i + 1));
        nw = (len + OUT_B - 1) / OUT_B;
        for (int w = 0; w < nw; w++) begin
            word_t e;
            e = '0;
            for (int b = 0; b < OUT_B; b++)
                if (w * OUT_B + b < len) e.data[b*8 +: 8] = pkt[w * OUT_B + b];
            e.sop   = (w == 0);
            e.eop   = (w == nw - 1);
            e.empty = e.eop ? EOW'(nw * OUT_B - len) : '0;
            e.ch    = ch;
            exp_q.push_back(e);
        end
        nb = (len + IN_B - 1) / IN_B;
        for (int bt = 0; bt < nb; bt++) begin
            logic [DIN-1:0] d;
            d = '0;
            for (int b = 0; b < IN_B; b++)
                if (bt * IN_B + b < len) d[b*8 +: 8] = pkt[bt * IN_B + b];
            drive_beat(d, bt == 0, bt == nb - 1, (bt == nb - 1) ? EIW'(nb * IN_B - len) : '0, ch);
        end
    endtask

    task automatic wait_drain();
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0 || ast_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL %s drain: %0d words outstanding, valid_o=%b, want 0 and 0", cur_test.name(), exp_q.size(), ast_valid_o);
            exp_q.delete();
        end
    endtask

    task automatic start_test(input test_case_e tc);
        cur_test   = tc;
        words_seen = 0;
        acc_t.delete();
    endtask

    task automatic test_reset();
        logic [DOUT+CW+EOW+3:0] outs;
        start_test(TEST_PLAIN);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        outs = {ast_valid_o, ast_startofpacket_o, ast_endofpacket_o, ast_ready_o, ast_data_o, ast_empty_o, ast_channel_o};
        n_cmp++;
        if (outs !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h, want 0", outs);
        end
        srst_i = 1'b0;
        #1;
        n_cmp++;
        if (ast_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready_after: got %b, want 1", ast_ready_o);
        end
    endtask

    task automatic test_plain();
        start_test(TEST_PLAIN);
        bp_mode = 0;
        send_packet(64, 10'd5, 1'b0);
        wait_drain();
        n_cmp++;
        if (words_seen != 8) begin
            n_err++;
            $display("FAIL plain_count: got %0d words, want 8", words_seen);
        end
        n_cmp++;
        if (acc_t.size() != 2 || acc_t[1] - acc_t[0] != 4 * 2 * HALF) begin
            n_err++;
            $display("FAIL plain_accept_spacing: got %0d accepts, want 2 spaced 4 cycles", acc_t.size());
        end
        n_cmp++;
        if (acc_t.size() == 0 || t_first - acc_t[0] != HALF + 1) begin
            n_err++;
            $display("FAIL plain_latency: first word %0t, want one cycle after accept", t_first);
        end
        n_cmp++;
        if (t_last - t_first != 7 * 2 * HALF) begin
            n_err++;
            $display("FAIL plain_gapless: span %0t, want %0d", t_last - t_first, 7 * 2 * HALF);
        end
    endtask

    task automatic test_empty();
        start_test(TEST_EMPTY);
        send_packet(37, 10'd3, 1'b1);
        wait_drain();
        n_cmp++;
        if (words_seen != 5) begin
            n_err++;
            $display("FAIL empty37_count: got %0d words, want 5", words_seen);
        end
        start_test(TEST_EMPTY);
        send_packet(1, 10'd2, 1'b0);
        send_packet(1, 10'd4, 1'b1);
        wait_drain();
        n_cmp++;
        if (words_seen != 2 || acc_t.size() != 2 || acc_t[1] - acc_t[0] != 2 * HALF) begin
            n_err++;
            $display("FAIL single_byte_back_to_back: got %0d words %0d accepts, want 2 words 1 cycle apart", words_seen, acc_t.size());
        end
    endtask

    task automatic test_backpressure();
        word_t snap;
        word_t cur;
        start_test(TEST_BACKPRESSURE);
        bp_mode = 2;
        fork
            send_packet(40, 10'd9, 1'b1);
            begin
                @(negedge clk);
                #1;
                for (int c = 0; c < 50 && ast_valid_o !== 1'b1; c++) begin
                    @(negedge clk);
                    #1;
                end
                snap = '{ast_data_o, ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_channel_o};
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    #1;
                    cur = '{ast_data_o, ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_channel_o};
                    n_cmp++;
                    if (cur !== snap || ast_valid_o !== 1'b1 || ast_ready_o !== 1'b0) begin
                        n_err++;
                        $display("FAIL stall_stable%0d: got %h valid=%b ready_o=%b, want %h valid=1 ready_o=0",
                                 c, cur, ast_valid_o, ast_ready_o, snap);
                    end
                end
                bp_mode = 0;
            end
        join
        wait_drain();
        n_cmp++;
        if (words_seen != 5) begin
            n_err++;
            $display("FAIL stall_count: got %0d words, want 5", words_seen);
        end
    endtask

    task automatic test_random_big();
        int total;
        int len;
        start_test(TEST_RANDOM_BIG);
        total = 0;
        bp_mode = 1;
        for (int p = 0; p < 100; p++) begin
            len = $urandom_range(PKT_LEN_MAX, PKT_LEN_MIN);
            total += (len + OUT_B - 1) / OUT_B;
            send_packet(len, CW'($urandom), 1'b1);
        end
        wait_drain();
        bp_mode = 0;
        n_cmp++;
        if (words_seen != total) begin
            n_err++;
            $display("FAIL random_count: got %0d words, want %0d", words_seen, total);
        end
    endtask

    task automatic test_channels();
        logic [CW-1:0] chs[3];
        logic [DIN-1:0] d;
        word_t e;
        start_test(TEST_CHANNELS);
        chs[0] = 10'd0;
        chs[1] = 10'd1023;
        chs[2] = 10'd17;
        for (int bt = 0; bt < 2; bt++) begin
            for (int k = 0; k < 3; k++) begin
                for (int j = 0; j < DIN / 32; j++) d[j*32 +: 32] = $urandom;
                for (int w = 0; w < 4; w++) begin
                    e.data  = d[w*DOUT +: DOUT];
                    e.sop   = (bt == 0) && (w == 0);
                    e.eop   = (bt == 1) && (w == 3);
                    e.empty = '0;
                    e.ch    = chs[k];
                    exp_q.push_back(e);
                end
                drive_beat(d, bt == 0, bt == 1, '0, chs[k]);
            end
        end
        wait_drain();
        n_cmp++;
        if (words_seen != 24) begin
            n_err++;
            $display("FAIL channels_count: got %0d words, want 24", words_seen);
        end
    endtask

    task automatic test_reset_mid();
        logic [DIN-1:0] d;
        word_t e;
        start_test(TEST_PLAIN);
        bp_mode = 0;
        for (int j = 0; j < DIN / 32; j++) d[j*32 +: 32] = $urandom;
        for (int w = 0; w < 2; w++) begin
            e.data  = d[w*DOUT +: DOUT];
            e.sop   = (w == 0);
            e.eop   = 1'b0;
            e.empty = '0;
            e.ch    = 10'd12;
            exp_q.push_back(e);
        end
        drive_beat(d, 1'b1, 1'b0, '0, 10'd12);
        @(negedge clk);
        @(negedge clk);
        #2;
        bp_mode = 2;
        @(negedge clk);
        #1;
        n_cmp++;
        if (ast_valid_o !== 1'b1 || ast_data_o !== d[2*DOUT +: DOUT]) begin
            n_err++;
            $display("FAIL midreset_word2: got valid=%b data=%h, want 1 %h", ast_valid_o, ast_data_o, d[2*DOUT +: DOUT]);
        end
        srst_i = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (ast_valid_o !== 1'b0 || ast_ready_o !== 1'b0 || ast_startofpacket_o !== 1'b0 || ast_endofpacket_o !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_flush: got valid=%b ready_o=%b sop=%b eop=%b, want all 0",
                     ast_valid_o, ast_ready_o, ast_startofpacket_o, ast_endofpacket_o);
        end
        srst_i = 1'b0;
        bp_mode = 0;
        #1;
        n_cmp++;
        if (ast_ready_o !== 1'b1 || words_seen != 2 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL midreset_release: got ready_o=%b words=%0d pending=%0d, want 1 2 0", ast_ready_o, words_seen, exp_q.size());
        end
        start_test(TEST_PLAIN);
        send_packet(50, 10'd7, 1'b1);
        wait_drain();
        n_cmp++;
        if (words_seen != 7) begin
            n_err++;
            $display("FAIL midreset_next_packet: got %0d words, want 7", words_seen);
        end
    endtask

    initial begin
        test_reset();
        test_plain();
        test_empty();
        test_backpressure();
        test_channels();
        test_random_big();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
